// File: rtl/button_debounce.sv
// Debounces a synchronized push-button level and reports press, release and long-press events.
// One FSM with registered outputs; every output changes only on the rising edge of clk.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LP_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] LP_MAX  = HW'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_db_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_pressed;
    logic            r_press_pulse;
    logic            r_release_pulse;
    logic            r_long_pulse;

    logic [HW-1:0]   w_hold_next;
    logic            w_long_hit;
    logic            w_db_done;

    // Hold counter parks at the threshold, so the L-1 match below fires at most once per press.
    assign w_hold_next = (r_hold_cnt == LP_MAX) ? r_hold_cnt : r_hold_cnt + HW'(1);
    assign w_long_hit  = (r_hold_cnt == LP_LAST);
    assign w_db_done   = (r_db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_db_cnt        <= '0;
            r_hold_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pressed  <= 1'b0;
                    r_hold_cnt <= '0;
                    if (sync) begin
                        r_state  <= PRESS_WAIT;
                        r_db_cnt <= DW'(1);
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        r_state  <= IDLE;
                        r_db_cnt <= '0;
                    end else if (w_db_done) begin
                        r_state       <= HELD;
                        r_db_cnt      <= '0;
                        r_hold_cnt    <= '0;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DW'(1);
                    end
                end
                HELD: begin
                    r_hold_cnt   <= w_hold_next;
                    r_long_pulse <= w_long_hit;
                    if (!sync) begin
                        r_state  <= RELEASE_WAIT;
                        r_db_cnt <= DW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    // An accepted release wins over a long-press landing on the same edge.
                    if (sync) begin
                        r_state      <= HELD;
                        r_db_cnt     <= '0;
                        r_hold_cnt   <= w_hold_next;
                        r_long_pulse <= w_long_hit;
                    end else if (w_db_done) begin
                        r_state         <= IDLE;
                        r_db_cnt        <= '0;
                        r_hold_cnt      <= '0;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_db_cnt     <= r_db_cnt + DW'(1);
                        r_hold_cnt   <= w_hold_next;
                        r_long_pulse <= w_long_hit;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_db_cnt <= '0;
                end
            endcase
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;

endmodule
